decrypt_sched: RTL and testbench

- Sequencing controller for the combinational AES-256 decryption core (`decryption`: 128-bit block in, 256-bit key, 256-bit sbox_seed, 128-bit block out).
- Holds the key and sbox_seed configuration and accepts ciphertext blocks over a valid/ready stream.
- Drives each block into the core and waits a programmable number of settle cycles, because the core is a multi-cycle combinational path.
- Returns the plaintext over a valid/ready stream with backpressure. Sits between the host/DMA stream and the decryption instance.

---
 rtl/decrypt_sched.sv | 126 ++++++++++++
 tb/tb_decrypt_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decrypt_sched.sv
// Sequencer for the combinational AES-256 decryption core; DECRYPT_CBC_EN adds CBC chaining.
// Latency: out_valid rises SETTLE_CYCLES edges after the accept edge; one block in flight.
// Backpressure: out_data is held in DONE until out_ready; in_ready stays low until the block retires.
module decrypt_sched #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_load,
  input  logic [255:0] cfg_key,
  input  logic [255:0] cfg_seed,
  input  logic [127:0] cfg_iv,
  output logic         cfg_rej,
  output logic         key_valid,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [127:0] core_in,
  output logic [255:0] core_key,
  output logic [255:0] core_seed,
  input  logic [127:0] core_out,
  output logic [15:0]  blk_cnt
);

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cfg_take, accept, capture, retire;
  logic [127:0]     plain;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    cfg_take  = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    retire    = 1'b0;
    case (state)
      IDLE: begin
        // a configuration load wins over a block offered in the same cycle
        in_ready = key_valid & ~cfg_load;
        cfg_take = cfg_load;
        accept   = in_valid & key_valid & ~cfg_load;
        if (accept) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          retire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

`ifdef DECRYPT_CBC_EN
  logic [127:0] chain;

  assign plain = core_out ^ chain;

  // chain holds the previous ciphertext block, or the IV after a load
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           chain <= '0;
    else if (cfg_take) chain <= cfg_iv;
    else if (capture)  chain <= core_in;
  end
`else
  logic unused_iv;

  assign plain     = core_out;
  assign unused_iv = ^cfg_iv;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_rej   <= 1'b0;
      key_valid <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      core_in   <= '0;
      core_key  <= '0;
      core_seed <= '0;
      blk_cnt   <= '0;
      cnt       <= '0;
    end else begin
      // loads outside IDLE are dropped so the core inputs stay frozen while settling
      cfg_rej <= cfg_load & (state != IDLE);
      if (cfg_take) begin
        core_key  <= cfg_key;
        core_seed <= cfg_seed;
        key_valid <= 1'b1;
      end
      if (accept) begin
        core_in <= in_data;
        cnt     <= CNT_W'(SETTLE_CYCLES - 1);
      end else if (state == SETTLE && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (capture) begin
        out_data  <= plain;
        out_valid <= 1'b1;
      end
      if (retire) begin
        out_valid <= 1'b0;
        blk_cnt   <= blk_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_decrypt_sched.sv
// Bench for decrypt_sched: XOR stub core, random traffic, queue scoreboard with a separate monitor.
// Build with +define+DECRYPT_CBC_EN to exercise the CBC chaining model.
module tb_decrypt_sched;
  localparam int S = 4;
  localparam logic [255:0] KEY0 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cfg_load = 1'b0;
  logic [255:0] cfg_key = '0;
  logic [255:0] cfg_seed = '0;
  logic [127:0] cfg_iv = '0;
  logic         cfg_rej, key_valid, in_ready, out_valid;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_data = '0;
  logic [127:0] out_data, core_in, core_out;
  logic [255:0] core_key, core_seed;
  logic [15:0]  blk_cnt;

  decrypt_sched #(.SETTLE_CYCLES(S), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .cfg_load(cfg_load), .cfg_key(cfg_key), .cfg_seed(cfg_seed), .cfg_iv(cfg_iv),
    .cfg_rej(cfg_rej), .key_valid(key_valid),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_in(core_in), .core_key(core_key), .core_seed(core_seed), .core_out(core_out),
    .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  assign core_out = core_in ^ core_key[127:0] ^ core_seed[127:0];

  int checks = 0, failures = 0, cyc = 0, retired = 0, stall = 0;
  bit busy = 1'b0, kv = 1'b0, rej_exp = 1'b0, mon_hold = 1'b0;
  logic [255:0] mkey = '0, mseed = '0;
`ifdef DECRYPT_CBC_EN
  logic [127:0] mchain = '0;
`endif
  logic [127:0] exp_q[$];
  int           acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: got timeout/extra event expected none", nm);
  endtask

  function automatic logic [127:0] r128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // one clock of stimulus; registered outputs from the previous edge are checked first
  task automatic step(input bit cl, input logic [255:0] k, input logic [255:0] s,
                      input logic [127:0] iv, input bit vld, input logic [127:0] d);
    bit exp_rdy;
    logic [127:0] exp_pt;
    @(posedge clk); #1;
    chk("key_valid", 256'(key_valid), 256'(kv));
    chk("core_key", core_key, mkey);
    chk("core_seed", core_seed, mseed);
    chk("cfg_rej", 256'(cfg_rej), 256'(rej_exp));
    if (!busy) chk("out_valid_idle", 256'(out_valid), 256'(0));
    exp_rdy = kv && !cl && !busy;
    rej_exp = cl && busy;
    cfg_load = cl; cfg_key = k; cfg_seed = s; cfg_iv = iv;
    in_valid = vld; in_data = d;
    #1;
    chk("in_ready", 256'(in_ready), 256'(exp_rdy));
    if (cl && !busy) begin
      mkey = k; mseed = s; kv = 1'b1;
`ifdef DECRYPT_CBC_EN
      mchain = iv;
`endif
    end
    if (vld && exp_rdy) begin
      exp_pt = d ^ mkey[127:0] ^ mseed[127:0];
`ifdef DECRYPT_CBC_EN
      exp_pt = exp_pt ^ mchain;
      mchain = d;
`endif
      busy = 1'b1;
      exp_q.push_back(exp_pt);
      acc_q.push_back(cyc + 1);
    end
  endtask

  task automatic idle_step();
    step(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) idle_step();
    if (busy) fail_now("wait_idle_timeout");
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    cfg_load = 1'b0; in_valid = 1'b1;
    busy = 1'b0; kv = 1'b0; rej_exp = 1'b0; retired = 0;
    mkey = '0; mseed = '0;
`ifdef DECRYPT_CBC_EN
    mchain = '0;
`endif
    exp_q.delete();
    acc_q.delete();
    #1;
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_key_valid", 256'(key_valid), 256'(0));
    chk("rst_in_ready", 256'(in_ready), 256'(0));
    chk("rst_blk_cnt", 256'(blk_cnt), 256'(0));
    chk("rst_core_key", core_key, 256'(0));
    chk("rst_core_in", 256'(core_in), 256'(0));
    chk("rst_out_data", 256'(out_data), 256'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // consumer: mostly ready, with occasional long stalls
  initial begin
    forever begin
      @(posedge clk); #1;
      if (stall > 0) begin
        out_ready = 1'b0;
        stall--;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 30) == 0) stall = 10;
      end
    end
  end

  // monitor: latency, held data and transfer checks against the expected queue
  initial begin
    forever begin
      @(negedge clk);
      chk("blk_cnt", 256'(blk_cnt), 256'(retired));
      if (out_valid) begin
        if (!mon_hold) begin
          if (acc_q.size() == 0) fail_now("latency_no_accept");
          else chk("latency", 256'(cyc - acc_q.pop_front()), 256'(S));
        end
        if (exp_q.size() == 0) begin
          fail_now("unexpected_out_valid");
        end else begin
          chk("out_data", 256'(out_data), 256'(exp_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            retired++;
            busy = 1'b0;
          end
        end
      end
      mon_hold = out_valid && !out_ready;
    end
  end

  initial begin
    logic [255:0] r;
    #1 rst = 1'b1;
    in_valid = 1'b1;
    in_data = r128();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // unconfigured: blocks must not be accepted
    step(1'b0, '0, '0, '0, 1'b1, r128());
    step(1'b0, '0, '0, '0, 1'b1, r128());

    // known-answer block
    step(1'b1, KEY0, '0, '1, 1'b0, '0);
    step(1'b0, '0, '0, '0, 1'b1, '0);
    wait_idle();

    // long backpressure while the result is waiting
    step(1'b0, '0, '0, '0, 1'b1, r128());
    stall = 14;
    wait_idle();

    // load and block together: load wins, block goes next cycle
    r = {r128(), r128()};
    step(1'b1, r, {r128(), r128()}, r128(), 1'b1, 128'h5a5a);
    step(1'b0, '0, '0, '0, 1'b1, 128'h5a5a);

    // load attempts while busy are rejected
    wait_idle();
    step(1'b0, '0, '0, '0, 1'b1, r128());
    step(1'b1, 256'h1, 256'h2, 128'h3, 1'b0, '0);
    idle_step();
    step(1'b1, 256'h1, 256'h2, 128'h3, 1'b0, '0);
    wait_idle();

    // key equals seed so the core is transparent; IV of all ones
    r = {r128(), r128()};
    step(1'b1, r, r, '1, 1'b0, '0);
    step(1'b0, '0, '0, '0, 1'b1, 128'h0);
    wait_idle();
    step(1'b0, '0, '0, '0, 1'b1, 128'h1);
    wait_idle();

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) == 0, {r128(), r128()}, {r128(), r128()}, r128(),
           $urandom_range(0, 1) == 1, r128());
    end
    wait_idle();

    // reset in the middle of a settle window drops the block
    step(1'b0, '0, '0, '0, 1'b1, r128());
    idle_step();
    do_reset();
    idle_step();
    idle_step();
    step(1'b1, KEY0, {r128(), r128()}, r128(), 1'b0, '0);
    step(1'b0, '0, '0, '0, 1'b1, r128());
    wait_idle();
    idle_step();

    if (exp_q.size() != 0) fail_now("scoreboard_not_empty");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
